// File: rtl/iir_ctrl_pkg.sv
// Shared types for the notch IIR chain configuration controller:
// FSM states, the bypass pair and its comparison helper.
package iir_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        APPLY  = 2'd2,
        SETTLE = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic bp_1mhz;
        logic bp_2_4mhz;
    } bypass_cfg_t;

    // Both notches in circuit.
    localparam bypass_cfg_t CFG_ACTIVE = '0;

    function automatic logic cfg_equal(input bypass_cfg_t a, input bypass_cfg_t b);
        return a == b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with synchronous clear (clr beats inc/dec).
// With UPDOWN=1, simultaneous inc and dec leave the count unchanged.
module sat_counter #(
    parameter int W      = 16,
    parameter bit UPDOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    logic up;
    logic down;

    assign up   = inc && !(UPDOWN && dec);
    assign down = UPDOWN && dec && !inc;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (up && cnt != '1)
            cnt <= cnt + W'(1);
        else if (down && cnt != '0)
            cnt <= cnt - W'(1);
    end

endmodule

// File: rtl/iir_chain_ctrl.sv
// Runtime bypass controller for the 2.4 MHz / 1 MHz notch chain: drain, apply, settle.
// Optional autonomous bypass on error threshold under IIR_CTRL_AUTO_BYPASS_EN.
module iir_chain_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int CNT_W          = 6,
    parameter int SETTLE_SAMPLES = 8,
    parameter int DRAIN_TIMEOUT  = 64,
    parameter int STAT_WIDTH     = 16
`ifdef IIR_CTRL_AUTO_BYPASS_EN
    ,
    parameter int AUTO_THRESH    = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  chain_valid_in,
    input  logic                  chain_valid_out,
    output logic                  valid_out,
    input  logic                  cfg_req,
    input  logic                  cfg_bypass_1MHz,
    input  logic                  cfg_bypass_2_4MHz,
    output logic                  cfg_ack,
    output logic                  cfg_reject,
    output logic                  busy,
    output logic                  bypass_1MHz,
    output logic                  bypass_2_4MHz,
    input  logic                  overflow_1MHz,
    input  logic                  underflow_1MHz,
    input  logic                  overflow_2_4MHz,
    input  logic                  underflow_2_4MHz,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] err_cnt_1MHz,
    output logic [STAT_WIDTH-1:0] err_cnt_2_4MHz,
    output logic [STAT_WIDTH-1:0] drop_cnt,
    output logic                  drain_timeout
`ifdef IIR_CTRL_AUTO_BYPASS_EN
    ,
    output logic                  auto_bypass_evt
`endif
);

    localparam int SET_W = (SETTLE_SAMPLES > 0) ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    ctrl_state_t       state;
    bypass_cfg_t       cur_cfg;
    bypass_cfg_t       pend_cfg;
    bypass_cfg_t       req_cfg;
    bypass_cfg_t       start_cfg;
    logic [SET_W-1:0]  settle_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CNT_W-1:0]  inflight;
    logic              gate_open;
    logic              drain_force;
    logic              auto_go;

    assign gate_open      = (state == IDLE) || (state == SETTLE);
    assign chain_valid_in = valid_in && gate_open;
    assign valid_out      = chain_valid_out && (state != SETTLE);
    assign busy           = (state != IDLE);
    assign bypass_1MHz    = cur_cfg.bp_1mhz;
    assign bypass_2_4MHz  = cur_cfg.bp_2_4mhz;

    assign req_cfg.bp_1mhz   = cfg_bypass_1MHz;
    assign req_cfg.bp_2_4mhz = cfg_bypass_2_4MHz;

    // A stuck chain must not hold the configuration hostage forever.
    assign drain_force = (state == DRAIN) && (inflight != '0) &&
                         (tmo_cnt == TMO_W'(DRAIN_TIMEOUT - 1));

`ifdef IIR_CTRL_AUTO_BYPASS_EN
    bypass_cfg_t auto_cfg;

    always_comb begin
        auto_cfg = cur_cfg;
        if (err_cnt_1MHz >= STAT_WIDTH'(AUTO_THRESH))
            auto_cfg.bp_1mhz = 1'b1;
        if (err_cnt_2_4MHz >= STAT_WIDTH'(AUTO_THRESH))
            auto_cfg.bp_2_4mhz = 1'b1;
    end

    // Only fires when it would actually change something, so it cannot loop on acks.
    assign auto_go   = (state == IDLE) && !cfg_req && !cfg_equal(auto_cfg, cur_cfg);
    assign start_cfg = cfg_req ? req_cfg : auto_cfg;

    always_ff @(posedge clk) begin
        if (rst)
            auto_bypass_evt <= 1'b0;
        else
            auto_bypass_evt <= auto_go;
    end
`else
    assign auto_go   = 1'b0;
    assign start_cfg = req_cfg;
`endif

    sat_counter #(.W(STAT_WIDTH)) u_err_1mhz (
        .clk(clk), .rst(rst), .clr(stat_clr),
        .inc(overflow_1MHz || underflow_1MHz), .dec(1'b0), .cnt(err_cnt_1MHz)
    );

    sat_counter #(.W(STAT_WIDTH)) u_err_2_4mhz (
        .clk(clk), .rst(rst), .clr(stat_clr),
        .inc(overflow_2_4MHz || underflow_2_4MHz), .dec(1'b0), .cnt(err_cnt_2_4MHz)
    );

    sat_counter #(.W(STAT_WIDTH)) u_drop (
        .clk(clk), .rst(rst), .clr(stat_clr),
        .inc(valid_in && !gate_open), .dec(1'b0), .cnt(drop_cnt)
    );

    sat_counter #(.W(CNT_W), .UPDOWN(1'b1)) u_inflight (
        .clk(clk), .rst(rst), .clr(drain_force),
        .inc(chain_valid_in), .dec(chain_valid_out), .cnt(inflight)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_cfg       <= CFG_ACTIVE;
            pend_cfg      <= CFG_ACTIVE;
            settle_cnt    <= '0;
            tmo_cnt       <= '0;
            cfg_ack       <= 1'b0;
            cfg_reject    <= 1'b0;
            drain_timeout <= 1'b0;
        end else begin
            cfg_ack    <= 1'b0;
            cfg_reject <= cfg_req && (state != IDLE);

            if (stat_clr)
                drain_timeout <= 1'b0;
            else if (drain_force)
                drain_timeout <= 1'b1;

            case (state)
                IDLE: begin
                    if (cfg_req || auto_go) begin
                        pend_cfg <= start_cfg;
                        if (cfg_equal(start_cfg, cur_cfg)) begin
                            cfg_ack <= 1'b1;
                        end else begin
                            state   <= DRAIN;
                            tmo_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (inflight == '0 || drain_force)
                        state <= APPLY;
                    else
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                APPLY: begin
                    cur_cfg    <= pend_cfg;
                    settle_cnt <= SET_W'(SETTLE_SAMPLES);
                    if (SETTLE_SAMPLES == 0) begin
                        state   <= IDLE;
                        cfg_ack <= 1'b1;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (chain_valid_out) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                        if (settle_cnt == SET_W'(1)) begin
                            state   <= IDLE;
                            cfg_ack <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_chain_ctrl.sv
// Scoreboard bench for iir_chain_ctrl: driver pushes reference-model expectations,
// a negedge monitor pops and compares every DUT output.
module tb_iir_chain_ctrl;

    localparam int SETTLE_N = 8;
    localparam int TMO      = 64;
    localparam int INF_MAX  = 63;
    localparam int STAT_MAX = 65535;
    localparam int M_IDLE = 0, M_DRAIN = 1, M_APPLY = 2, M_SETTLE = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid_in, chain_valid_in, chain_valid_out, valid_out;
    logic cfg_req, cfg_bypass_1MHz, cfg_bypass_2_4MHz, cfg_ack, cfg_reject, busy;
    logic bypass_1MHz, bypass_2_4MHz;
    logic overflow_1MHz, underflow_1MHz, overflow_2_4MHz, underflow_2_4MHz;
    logic stat_clr, drain_timeout;
    logic [15:0] err_cnt_1MHz, err_cnt_2_4MHz, drop_cnt;

    iir_chain_ctrl #(.CNT_W(6), .SETTLE_SAMPLES(SETTLE_N), .DRAIN_TIMEOUT(TMO), .STAT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .chain_valid_in(chain_valid_in),
        .chain_valid_out(chain_valid_out), .valid_out(valid_out), .cfg_req(cfg_req),
        .cfg_bypass_1MHz(cfg_bypass_1MHz), .cfg_bypass_2_4MHz(cfg_bypass_2_4MHz),
        .cfg_ack(cfg_ack), .cfg_reject(cfg_reject), .busy(busy),
        .bypass_1MHz(bypass_1MHz), .bypass_2_4MHz(bypass_2_4MHz),
        .overflow_1MHz(overflow_1MHz), .underflow_1MHz(underflow_1MHz),
        .overflow_2_4MHz(overflow_2_4MHz), .underflow_2_4MHz(underflow_2_4MHz),
        .stat_clr(stat_clr), .err_cnt_1MHz(err_cnt_1MHz), .err_cnt_2_4MHz(err_cnt_2_4MHz),
        .drop_cnt(drop_cnt), .drain_timeout(drain_timeout)
    );

    typedef struct {
        int cyc;
        bit cvi, vo, busy, ack, rej, bp1, bp24, dto;
        int drop, e1, e24;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Stimulus for the next cycle; cleared after every tick.
    bit s_rst, s_vin, s_cvo, s_req, s_q1, s_q24, s_o1, s_u1, s_o24, s_u24, s_clr;

    // Reference model state.
    int m_mode, m_infl, m_tmo, m_hide, m_drop, m_e1, m_e24;
    bit m_w1, m_w24, m_bp1, m_bp24, m_ack, m_rej, m_dto;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : ((v < 0) ? 0 : v);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_infl = 0; m_tmo = 0; m_hide = 0;
        m_drop = 0; m_e1 = 0; m_e24 = 0;
        m_w1 = 0; m_w24 = 0; m_bp1 = 0; m_bp24 = 0; m_ack = 0; m_rej = 0; m_dto = 0;
    endtask

    task automatic tick();
        exp_t e;
        bit   open, cvi, forced;
        int   om;
        @(posedge clk); #1;
        rst = s_rst; valid_in = s_vin; chain_valid_out = s_cvo; cfg_req = s_req;
        cfg_bypass_1MHz = s_q1; cfg_bypass_2_4MHz = s_q24;
        overflow_1MHz = s_o1; underflow_1MHz = s_u1;
        overflow_2_4MHz = s_o24; underflow_2_4MHz = s_u24; stat_clr = s_clr;
        cyc++;
        open = (m_mode == M_IDLE) || (m_mode == M_SETTLE);
        cvi  = s_vin && open;
        e.cyc = cyc; e.cvi = cvi; e.vo = s_cvo && (m_mode != M_SETTLE);
        e.busy = (m_mode != M_IDLE); e.ack = m_ack; e.rej = m_rej;
        e.bp1 = m_bp1; e.bp24 = m_bp24; e.dto = m_dto;
        e.drop = m_drop; e.e1 = m_e1; e.e24 = m_e24;
        sbq.push_back(e);
        if (s_rst) begin
            model_reset();
        end else begin
            om     = m_mode;
            forced = (om == M_DRAIN) && (m_infl > 0) && (m_tmo == TMO - 1);
            m_rej  = s_req && (om != M_IDLE);
            m_ack  = 0;
            m_drop = s_clr ? 0 : sat(m_drop + int'(s_vin && !open), STAT_MAX);
            m_e1   = s_clr ? 0 : sat(m_e1 + int'(s_o1 || s_u1), STAT_MAX);
            m_e24  = s_clr ? 0 : sat(m_e24 + int'(s_o24 || s_u24), STAT_MAX);
            m_dto  = s_clr ? 0 : (forced ? 1'b1 : m_dto);
            case (om)
                M_IDLE: if (s_req) begin
                    m_w1 = s_q1; m_w24 = s_q24;
                    if (s_q1 == m_bp1 && s_q24 == m_bp24) m_ack = 1;
                    else begin m_mode = M_DRAIN; m_tmo = 0; end
                end
                M_DRAIN: if (m_infl == 0 || forced) m_mode = M_APPLY; else m_tmo++;
                M_APPLY: begin
                    m_bp1 = m_w1; m_bp24 = m_w24; m_hide = SETTLE_N; m_mode = M_SETTLE;
                end
                default: if (s_cvo) begin
                    m_hide--;
                    if (m_hide == 0) begin m_mode = M_IDLE; m_ack = 1; end
                end
            endcase
            m_infl = forced ? 0 : sat(m_infl + int'(cvi) - int'(s_cvo), INF_MAX);
        end
        {s_rst, s_vin, s_cvo, s_req, s_q1, s_q24, s_o1, s_u1, s_o24, s_u24, s_clr} = '0;
    endtask

    task automatic cmp(input string n, input int c, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", n, c, act, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cmp("chain_valid_in", e.cyc, int'(chain_valid_in), int'(e.cvi));
                cmp("valid_out",      e.cyc, int'(valid_out),      int'(e.vo));
                cmp("busy",           e.cyc, int'(busy),           int'(e.busy));
                cmp("cfg_ack",        e.cyc, int'(cfg_ack),        int'(e.ack));
                cmp("cfg_reject",     e.cyc, int'(cfg_reject),     int'(e.rej));
                cmp("bypass_1MHz",    e.cyc, int'(bypass_1MHz),    int'(e.bp1));
                cmp("bypass_2_4MHz",  e.cyc, int'(bypass_2_4MHz),  int'(e.bp24));
                cmp("drain_timeout",  e.cyc, int'(drain_timeout),  int'(e.dto));
                cmp("drop_cnt",       e.cyc, int'(drop_cnt),       e.drop);
                cmp("err_cnt_1MHz",   e.cyc, int'(err_cnt_1MHz),   e.e1);
                cmp("err_cnt_2_4MHz", e.cyc, int'(err_cnt_2_4MHz), e.e24);
            end
        end
    end

    task automatic run_until_idle(input int max_cyc);
        for (int n = 0; n < max_cyc && m_mode != M_IDLE; n++) begin
            s_cvo = 1'($urandom_range(0, 1));
            tick();
        end
        tick();
    endtask

    task automatic run_until_settle(input int max_cyc);
        for (int n = 0; n < max_cyc && m_mode != M_SETTLE; n++) begin
            s_cvo = (m_mode == M_DRAIN);
            tick();
        end
    endtask

    initial begin : stim
        {rst, valid_in, chain_valid_out, cfg_req, cfg_bypass_1MHz, cfg_bypass_2_4MHz} = 6'b100000;
        {overflow_1MHz, underflow_1MHz, overflow_2_4MHz, underflow_2_4MHz, stat_clr} = '0;
        {s_rst, s_vin, s_cvo, s_req, s_q1, s_q24, s_o1, s_u1, s_o24, s_u24, s_clr} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        s_rst = 1; tick();
        tick();

        // Bypass 1 MHz notch with no traffic.
        s_req = 1; s_q1 = 1; tick();
        repeat (4) tick();
        run_until_idle(200);

        // Five samples in flight, three dropped during drain.
        repeat (5) begin s_vin = 1; tick(); end
        s_req = 1; s_q1 = 1; s_q24 = 1; tick();
        repeat (3) begin s_vin = 1; tick(); end
        repeat (5) begin s_cvo = 1; tick(); end
        run_until_idle(200);

        // Drain timeout with a stuck chain.
        repeat (3) begin s_vin = 1; tick(); end
        s_req = 1; s_q24 = 1; tick();
        repeat (70) begin s_vin = 1'($urandom_range(0, 1)); tick(); end
        run_until_idle(200);
        repeat (3) tick();
        s_clr = 1; tick();
        tick();

        // Matching request, then a reject during settle.
        s_req = 1; s_q1 = m_bp1; s_q24 = m_bp24; tick();
        tick();
        s_req = 1; s_q1 = !m_bp1; s_q24 = m_bp24; tick();
        run_until_settle(200);
        s_req = 1; s_q1 = !m_w1; s_q24 = !m_w24; tick();
        run_until_idle(200);

        // Error counter saturation, then clear on a coincident overflow.
        repeat (70000) begin s_o24 = 1; tick(); end
        s_o24 = 1; s_clr = 1; tick();
        tick();

        // Reset in the middle of settling.
        s_req = 1; s_q1 = !m_bp1; s_q24 = !m_bp24; tick();
        run_until_settle(200);
        s_cvo = 1; tick();
        s_rst = 1; tick();
        repeat (4) begin s_cvo = 1'($urandom_range(0, 1)); tick(); end

        // Random traffic, requests, flags, clears and occasional resets.
        repeat (3000) begin
            s_vin = ($urandom_range(0, 99) < 50);
            s_cvo = ($urandom_range(0, 99) < 40);
            s_req = ($urandom_range(0, 99) < 5);
            s_q1  = 1'($urandom_range(0, 1));
            s_q24 = 1'($urandom_range(0, 1));
            s_o1  = ($urandom_range(0, 99) < 10);
            s_u1  = ($urandom_range(0, 99) < 10);
            s_o24 = ($urandom_range(0, 99) < 10);
            s_u24 = ($urandom_range(0, 99) < 10);
            s_clr = ($urandom_range(0, 99) < 1);
            s_rst = ($urandom_range(0, 199) < 1);
            tick();
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_chain_ctrl.md
Name: iir_chain_ctrl

Overview:
Runtime configuration controller for the two-stage notch IIR chain (2.4 MHz notch followed by 1 MHz notch).
- Owns both bypass controls and gates the chain's input valid.
- On a host bypass change, it drains in-flight samples, applies the new bypass pair, then masks the transient outputs while the filter state settles.
- Also keeps saturating overflow/underflow and dropped-sample statistics.

Parameters:
CNT_W, 6, width of the in-flight sample counter (saturates at 2^CNT_W-1).
SETTLE_SAMPLES, 8, number of chain outputs masked after a bypass change; 0 disables masking.
DRAIN_TIMEOUT, 64, maximum number of cycles spent in DRAIN before a forced apply.
STAT_WIDTH, 16, width of the statistics counters.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
valid_in  in  1  upstream sample valid
chain_valid_in  out  1  gated valid to the chain input (combinational)
chain_valid_out  in  1  valid from the chain output
valid_out  out  1  masked output valid (combinational)
cfg_req  in  1  single-cycle request to load a new configuration
cfg_bypass_1MHz  in  1  requested bypass for the 1 MHz notch, sampled with cfg_req
cfg_bypass_2_4MHz  in  1  requested bypass for the 2.4 MHz notch, sampled with cfg_req
cfg_ack  out  1  one-cycle pulse when the new configuration is live
cfg_reject  out  1  one-cycle pulse when cfg_req arrives while busy
busy  out  1  high in every state except IDLE
bypass_1MHz  out  1  registered bypass for the 1 MHz notch
bypass_2_4MHz  out  1  registered bypass for the 2.4 MHz notch
overflow_1MHz, underflow_1MHz, overflow_2_4MHz, underflow_2_4MHz  in  1 each  chain status flags
stat_clr  in  1  synchronous clear of all statistics
err_cnt_1MHz  out  STAT_WIDTH  count of cycles with overflow_1MHz or underflow_1MHz
err_cnt_2_4MHz  out  STAT_WIDTH  count of cycles with overflow_2_4MHz or underflow_2_4MHz
drop_cnt  out  STAT_WIDTH  count of valid_in samples dropped while gated
drain_timeout  out  1  sticky flag; cleared by rst or stat_clr

Behaviour:
Reset (rst=1 at a clk edge):
- State = IDLE; bypass outputs = 0 (both filters active).
- All counters = 0; cfg_ack = cfg_reject = drain_timeout = 0.

In-flight counter:
- +1 on chain_valid_in; -1 on chain_valid_out; unchanged when both or neither occur.
- Saturates at both ends.

Valid gating:
- chain_valid_in = valid_in in IDLE and SETTLE; 0 in DRAIN and APPLY.
- A valid_in arriving in DRAIN or APPLY is dropped and increments drop_cnt.
- valid_out = chain_valid_out except in SETTLE, where it is forced to 0. Drain-phase outputs pass through.

FSM:
- IDLE: on cfg_req, latch the requested pair.
  - If the pair equals the current bypass pair, pulse cfg_ack next cycle and stay in IDLE.
  - Otherwise go to DRAIN and clear the timeout counter.
- DRAIN: go to APPLY when in-flight == 0.
  - If the timeout counter reaches DRAIN_TIMEOUT-1, set drain_timeout, clear the in-flight counter, and go to APPLY.
- APPLY: one cycle. Registers the latched pair into the bypass outputs and loads settle = SETTLE_SAMPLES.
  - If SETTLE_SAMPLES == 0, go to IDLE and pulse cfg_ack.
  - Otherwise go to SETTLE.
- SETTLE: each chain_valid_out decrements settle. When it reaches 0, go to IDLE with a cfg_ack pulse on the same edge.

cfg_req handling:
- cfg_req in any state other than IDLE is ignored and pulses cfg_reject.

Statistics:
- Counters saturate at all-ones.
- stat_clr has priority over a same-cycle increment.

Mid-operation reset:
- rst in any state returns to IDLE immediately.
- Bypass outputs return to 0, and no cfg_ack is emitted.

Optional Feature:
Macro IIR_CTRL_AUTO_BYPASS_EN.
- When defined:
  - Adds parameter AUTO_THRESH (default 255) and output auto_bypass_evt.
  - When an error counter reaches AUTO_THRESH while in IDLE and no cfg_req is present, the FSM starts an internal request with that filter's bypass set to 1 and the other filter's bypass unchanged.
  - auto_bypass_evt pulses for one cycle at that start.
  - cfg_req wins in a same-cycle tie; the auto request retries on the next IDLE cycle.
- When undefined: no extra port or parameter, and no autonomous reconfiguration.

Decomposition:
Package iir_ctrl_pkg contains:
- the state enum (IDLE, DRAIN, APPLY, SETTLE);
- the bypass-configuration struct;
- a function comparing two configurations.

Sub-module sat_counter (width parameter; inc and clr inputs; clr has priority) is instantiated four times: the two error counters, the drop counter, and the in-flight counter in up/down mode.

Test Plan:
1. Reset, then cfg_req with 1MHz=1 and no traffic → DRAIN → APPLY → SETTLE.
   - bypass_1MHz = 1 on the APPLY edge; cfg_ack pulses after 8 chain_valid_out events.
2. 5 samples in flight, then cfg_req with 3 valid_in during DRAIN.
   - DRAIN lasts until the 5 outputs pass through valid_out; drop_cnt = 3.
3. chain_valid_out never returns during DRAIN.
   - APPLY is forced 64 cycles after entering DRAIN; drain_timeout = 1 until stat_clr.
4. cfg_req matching the current configuration → cfg_ack on the next cycle, busy stays 0.
   - A second cfg_req during SETTLE pulses cfg_reject, and the configuration is unchanged.
5. Hold overflow_2_4MHz high for 70000 cycles → err_cnt_2_4MHz = 65535.
   - stat_clr coincident with overflow → next value = 0.
6. rst asserted in SETTLE → next cycle state IDLE, bypass outputs = 0, valid_out follows chain_valid_out, no cfg_ack.
